pulse_stretch_arbiter: RTL and testbench

- Shares one pulse-stretch output channel among NREQ independent single-cycle pulse requesters.
- Each request event is latched, arbitrated round-robin and then stretched to a programmable length on out_pulse, with out_id naming the source.
- Enforces a programmable low gap between consecutive stretched pulses and flags events lost to oversubscription.
- Sits between event sources (sensors, timers) and the shared indicator/strobe line downstream.

---
 rtl/pulse_stretch_arbiter.sv | 152 +++++++++++++++
 tb/tb_pulse_stretch_arbiter.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/pulse_stretch_arbiter.sv
// Round-robin arbiter sharing one stretched-pulse output among NREQ requesters.
// Ports: clk, rst_n (sync, active low), req_pulse, cfg_we, cfg_len, ovf_clr,
//        out_pulse, out_id, busy, pending, ovf.
module pulse_stretch_arbiter #(
  parameter int NREQ    = 4,
  parameter int CNT_W   = 4,
  parameter int DEF_LEN = 5,
  parameter int GAP     = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_pulse,
  input  logic                    cfg_we,
  input  logic [CNT_W-1:0]        cfg_len,
  input  logic                    ovf_clr,
  output logic                    out_pulse,
  output logic [$clog2(NREQ)-1:0] out_id,
  output logic                    busy,
  output logic [NREQ-1:0]         pending,
  output logic [NREQ-1:0]         ovf
);

  localparam int ID_W = $clog2(NREQ);
  localparam int GW   = 3;
  localparam logic [ID_W:0] NR = (ID_W+1)'(NREQ);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STRETCH,
    ST_GAP
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] len_reg, len_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [GW-1:0]    gcnt, gcnt_n;
  logic [ID_W-1:0]  ptr, ptr_n;
  logic [ID_W-1:0]  id_q, id_n;
  logic [NREQ-1:0]  pend, pend_n;
  logic [NREQ-1:0]  ovf_q, ovf_n;
  logic [NREQ-1:0]  cand, gnt;
  logic [ID_W-1:0]  win;
  logic [ID_W:0]    nxt;
  logic             grant;

  assign cand = pend | req_pulse;

  // Rotate candidates so the search start sits at bit 0, then take
  // the lowest set bit and map the offset back to a requester index.
  logic [2*NREQ-1:0] dbl;
  logic [ID_W:0]     off, sum;
  logic              found;

  always_comb begin
    dbl   = {cand, cand} >> ptr;
    off   = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && dbl[k]) begin
        found = 1'b1;
        off   = (ID_W+1)'(k);
      end
    end
    sum = {1'b0, ptr} + off;
    if (sum >= NR) sum = sum - NR;
    win = sum[ID_W-1:0];
    nxt = {1'b0, win} + 1'b1;
    if (nxt == NR) nxt = '0;
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    gcnt_n  = gcnt;
    id_n    = id_q;
    ptr_n   = ptr;
    grant   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (|cand) grant = 1'b1;
      end
      ST_STRETCH: begin
        if (cnt != '0) begin
          cnt_n = cnt - 1'b1;
        end else if (GAP > 0) begin
          state_n = ST_GAP;
          gcnt_n  = GW'(GAP - 1);
        end else if (|cand) begin
          grant = 1'b1;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_GAP: begin
        if (gcnt != '0) gcnt_n = gcnt - 1'b1;
        else if (|cand) grant = 1'b1;
        else state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
    if (grant) begin
      state_n = ST_STRETCH;
      cnt_n   = len_reg - 1'b1;
      id_n    = win;
      ptr_n   = nxt[ID_W-1:0];
    end
  end

  // A request that coincides with its own grant is consumed by it.
  always_comb begin
    gnt = '0;
    if (grant) gnt[win] = 1'b1;
    pend_n = pend;
    ovf_n  = ovf_clr ? '0 : ovf_q;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) pend_n[i] = 1'b0;
      else if (req_pulse[i] && pend[i]) ovf_n[i] = 1'b1;
      else if (req_pulse[i]) pend_n[i] = 1'b1;
    end
    len_n = len_reg;
    if (cfg_we) len_n = (cfg_len == '0) ? CNT_W'(1) : cfg_len;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      gcnt    <= '0;
      ptr     <= '0;
      id_q    <= '0;
      pend    <= '0;
      ovf_q   <= '0;
      len_reg <= CNT_W'(DEF_LEN);
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      gcnt    <= gcnt_n;
      ptr     <= ptr_n;
      id_q    <= id_n;
      pend    <= pend_n;
      ovf_q   <= ovf_n;
      len_reg <= len_n;
    end
  end

  assign out_pulse = (state == ST_STRETCH);
  assign busy      = (state != ST_IDLE);
  assign out_id    = id_q;
  assign pending   = pend;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_pulse_stretch_arbiter.sv
// Bench for pulse_stretch_arbiter: GAP=1 and GAP=0 instances against
// a timeline model (grant edge, length, earliest next grant).
module tb_pulse_stretch_arbiter;

  localparam int N  = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req;
  logic          cfg_we;
  logic [CW-1:0] cfg_len;
  logic          ovf_clr;

  logic          op0, op1, bz0, bz1;
  logic [1:0]    id0, id1;
  logic [N-1:0]  pd0, pd1, ov0, ov1;

  always #5 clk = ~clk;

  pulse_stretch_arbiter #(.NREQ(N), .CNT_W(CW), .DEF_LEN(5), .GAP(1)) u0 (
    .clk(clk), .rst_n(rst_n), .req_pulse(req), .cfg_we(cfg_we),
    .cfg_len(cfg_len), .ovf_clr(ovf_clr), .out_pulse(op0),
    .out_id(id0), .busy(bz0), .pending(pd0), .ovf(ov0)
  );

  pulse_stretch_arbiter #(.NREQ(N), .CNT_W(CW), .DEF_LEN(5), .GAP(0)) u1 (
    .clk(clk), .rst_n(rst_n), .req_pulse(req), .cfg_we(cfg_we),
    .cfg_len(cfg_len), .ovf_clr(ovf_clr), .out_pulse(op1),
    .out_id(id1), .busy(bz1), .pending(pd1), .ovf(ov1)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int           gapv[2] = '{1, 0};
  int           m_e[2], m_cl[2], m_ok[2], m_ptr[2], m_len[2], m_id[2];
  logic [N-1:0] m_pend[2], m_ovf[2];

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_edge(int g);
    logic [N-1:0] cand, gnt;
    int w;
    if (!rst_n) begin
      m_e[g] = -1000; m_cl[g] = 1; m_ok[g] = cyc + 1;
      m_ptr[g] = 0; m_len[g] = 5; m_id[g] = 0;
      m_pend[g] = '0; m_ovf[g] = '0;
      return;
    end
    cand = m_pend[g] | req;
    gnt  = '0;
    if (cyc >= m_ok[g] && cand != '0) begin
      w = 0;
      for (int i = N - 1; i >= 0; i--) begin
        int j;
        j = (m_ptr[g] + i) % N;
        if (cand[j]) w = j;
      end
      gnt[w]   = 1'b1;
      m_e[g]   = cyc;
      m_cl[g]  = m_len[g];
      m_ok[g]  = cyc + m_len[g] + gapv[g];
      m_id[g]  = w;
      m_ptr[g] = (w + 1) % N;
    end
    if (ovf_clr) m_ovf[g] = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt[i]) m_pend[g][i] = 1'b0;
      else if (req[i] && m_pend[g][i]) m_ovf[g][i] = 1'b1;
      else if (req[i]) m_pend[g][i] = 1'b1;
    end
    if (cfg_we) m_len[g] = (cfg_len == 0) ? 1 : int'(cfg_len);
  endtask

  function automatic logic exp_pulse(int g);
    return cyc >= m_e[g] && cyc < m_e[g] + m_cl[g];
  endfunction

  function automatic logic exp_busy(int g);
    return cyc >= m_e[g] && cyc < m_e[g] + m_cl[g] + gapv[g];
  endfunction

  task automatic step();
    @(posedge clk);
    cyc++;
    model_edge(0);
    model_edge(1);
    #1;
    chk("g1_pulse", op0, exp_pulse(0));
    chk("g1_busy",  bz0, exp_busy(0));
    chk("g1_id",    id0, m_id[0]);
    chk("g1_pend",  pd0, m_pend[0]);
    chk("g1_ovf",   ov0, m_ovf[0]);
    chk("g0_pulse", op1, exp_pulse(1));
    chk("g0_busy",  bz1, exp_busy(1));
    chk("g0_id",    id1, m_id[1]);
    chk("g0_pend",  pd1, m_pend[1]);
    chk("g0_ovf",   ov1, m_ovf[1]);
  endtask

  task automatic idle(int n);
    req = '0;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    rst_n = 1'b0; req = '0; cfg_we = 1'b0;
    cfg_len = '0; ovf_clr = 1'b0;
    step(); step();
    rst_n = 1'b1;
    idle(2);

    req = 4'b0010; step(); idle(10);

    req = 4'b1011; step(); idle(25);

    for (int i = 0; i < 40; i++) begin
      req = 4'b0101; step();
    end
    req = '0; ovf_clr = 1'b1; step();
    ovf_clr = 1'b0; idle(20);

    req = 4'b0011; step(); idle(2);
    cfg_we = 1'b1; cfg_len = 4'd3; step();
    cfg_we = 1'b0; idle(15);
    cfg_we = 1'b1; cfg_len = 4'd0; step();
    cfg_we = 1'b0;
    req = 4'b0111; step(); idle(12);
    cfg_we = 1'b1; cfg_len = 4'd5; step();
    cfg_we = 1'b0; idle(2);

    req = 4'b0001; step(); idle(2);
    rst_n = 1'b0; step();
    rst_n = 1'b1; step();
    req = 4'b0100; step(); idle(10);

    for (int i = 0; i < 3000; i++) begin
      req     = N'($urandom & $urandom);
      cfg_we  = ($urandom_range(0, 15) == 0);
      cfg_len = CW'($urandom);
      ovf_clr = ($urandom_range(0, 19) == 0);
      rst_n   = ($urandom_range(0, 299) != 0);
      step();
    end
    rst_n = 1'b1; cfg_we = 1'b0; ovf_clr = 1'b0;
    idle(40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
